icache_line_fill: RTL and testbench
===================================

# icache_line_fill

Line-fill engine for the instruction cache. On a miss it accepts a line address from the cache controller, issues one burst read to the memory side, assembles the returned beats into a full cache line, and writes that line into the 16 x 256-bit icache data array SRAM through the array's write port. It sits directly upstream of the data array's port 0. While it is busy it owns that port; the cache controller owns the port at all other times.

## Interface
- `ADDR_WIDTH`, 32, byte-address width.
- `LINE_WIDTH`, 256, line width in bits. Must match the data array word.
- `BEAT_WIDTH`, 64, memory response width. `BEATS = LINE_WIDTH/BEAT_WIDTH` = 4.
- `INDEX_WIDTH`, 4, data-array address width. Index = `addr[INDEX_WIDTH+4:5]`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `miss_valid` in 1: controller requests a fill.
- `miss_addr` in ADDR_WIDTH: miss byte address.
- `miss_ready` out 1: fill engine idle; miss accepted when valid && ready.
- `mem_req_valid` out 1: burst read request.
- `mem_req_addr` out ADDR_WIDTH: line-aligned address (`miss_addr` with bits [4:0] = 0).
- `mem_req_ready` in 1: memory accepts the request.
- `mem_resp_valid` in 1: one response beat valid. There is no back-pressure.
- `mem_resp_data` in BEAT_WIDTH: beat data. Beats return in ascending address order.
- `data_csb` out 1: array chip select, active low.
- `data_web` out 1: array write enable, active low.
- `data_wmask` out LINE_WIDTH/8: array byte write mask.
- `data_addr` out INDEX_WIDTH: array address.
- `data_din` out LINE_WIDTH: array write data.
- `fill_busy` out 1: fill engine owns the array port; the controller must not drive it.
- `fill_done` out 1: one-cycle pulse when the line is committed in the array.
- `fill_line` out LINE_WIDTH: assembled line. Meaningful only when the `ICACHE_FILL_BYPASS_EN` macro is defined.

## Operation
- States: IDLE, REQ, RECV, WRITE, COMMIT.
- **IDLE**
  - `miss_ready`=1.
  - On `miss_valid`: latch the aligned line address; go to REQ.
- **REQ**
  - `mem_req_valid`=1 and `mem_req_addr` are held stable until `mem_req_ready`.
  - On ready: clear the beat counter (2 bits); go to RECV.
- **RECV**
  - Each `mem_resp_valid` stores `mem_resp_data` into line bits `[64*cnt +: 64]` and increments the counter.
  - Gaps between beats are allowed.
  - The beat accepted with cnt==3 moves the FSM to WRITE.
- **WRITE** (one cycle)
  - `data_csb`=0, `data_web`=0, `data_wmask` all ones, `data_addr`=index, `data_din`=assembled line.
  - Go to COMMIT.
- **COMMIT** (one cycle)
  - `fill_done`=1; go to IDLE.
  - The array's internal write lands at the end of this cycle.
- `fill_busy`=1 in REQ, RECV, WRITE and COMMIT.
  - Array outputs are driven only in WRITE.
  - Outside WRITE: `data_csb`=1, `data_web`=1, `data_wmask`=0, `data_addr`=0, `data_din`=0.
- `miss_valid` outside IDLE is ignored; `miss_ready`=0.
- `mem_resp_valid` outside RECV is ignored and does not change the line buffer.
- Reset (any state):
  - FSM goes to IDLE, beat counter and line buffer clear.
  - Any in-flight fill is discarded with no array write.
- Reset values:
  - `miss_ready`=1, `mem_req_valid`=0, `mem_req_addr`=0.
  - `data_csb`=1, `data_web`=1, `data_wmask`=0, `data_addr`=0, `data_din`=0.
  - `fill_busy`=0, `fill_done`=0, `fill_line`=0.

## Timing
- All outputs are registered or decoded from FSM state. There is no combinational path from inputs to `miss_ready` or `mem_req_valid`.
- Best case (immediate ready, 4 back-to-back beats):
  - Miss accepted at edge 0.
  - REQ in cycle 1; RECV in cycles 2–5; WRITE in cycle 6; COMMIT in cycle 7.
  - IDLE in cycle 8 with `miss_ready`=1.
- A controller read of the filled index may be presented in the COMMIT cycle or later. Its data is valid the following cycle.
- A new miss is accepted no earlier than the cycle after COMMIT.

## Configuration
- `ICACHE_FILL_BYPASS_EN` defined:
  - `fill_line` holds the assembled line from WRITE through COMMIT.
  - The controller may return the fetched instruction in the `fill_done` cycle without re-reading the array.
- Undefined:
  - `fill_line` is tied to 0.
  - The controller re-reads the array after `fill_done`.
  - FSM timing is identical in both cases.

## Test plan
- Reset, then `miss_addr`=0x0000_01A4, ready immediate, beats 0x11..11 / 0x22..22 / 0x33..33 / 0x44..44 back-to-back:
  - `mem_req_addr`=0x0000_01A0.
  - WRITE at cycle 6 with `data_addr`=0xD, `data_wmask`=0xFFFF_FFFF, `data_din`={0x44..,0x33..,0x22..,0x11..}.
  - `fill_done` at cycle 7.
- `mem_req_ready` held low for 5 cycles:
  - `mem_req_valid` and `mem_req_addr` stay stable throughout.
  - WRITE is delayed by exactly 5 cycles.
- Beats with 2-cycle gaps, plus a spurious `mem_resp_valid` during REQ:
  - The spurious beat is ignored.
  - The line matches the 4 in-RECV beats in order.
- `miss_valid` asserted during RECV: `miss_ready`=0 and no second request is issued. After COMMIT the miss is accepted.
- `rst_n` pulsed low after the 2nd beat:
  - All outputs return to reset values immediately.
  - No WRITE occurs.
  - A following miss fills correctly from an empty buffer.
- With `ICACHE_FILL_BYPASS_EN` defined, `fill_line`==`data_din` during WRITE and COMMIT. Undefined, `fill_line`=0 throughout.

Source files
------------

// File: rtl/icache_line_fill.sv
// Icache line-fill engine: miss -> burst read -> assemble line -> array write.
// ICACHE_FILL_BYPASS_EN exposes the assembled line on fill_line.
module icache_line_fill #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int BEAT_WIDTH  = 64,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    miss_valid,
  input  logic [ADDR_WIDTH-1:0]   miss_addr,
  output logic                    miss_ready,
  output logic                    mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [BEAT_WIDTH-1:0]   mem_resp_data,
  output logic                    data_csb,
  output logic                    data_web,
  output logic [LINE_WIDTH/8-1:0] data_wmask,
  output logic [INDEX_WIDTH-1:0]  data_addr,
  output logic [LINE_WIDTH-1:0]   data_din,
  output logic                    fill_busy,
  output logic                    fill_done,
  output logic [LINE_WIDTH-1:0]   fill_line
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RECV,
    WRITE,
    COMMIT
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [INDEX_WIDTH-1:0]  index;

  assign index        = addr_q[INDEX_WIDTH+OFF_W-1:OFF_W];
  assign mem_req_addr = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && miss_valid)
        addr_q <= miss_addr & ~OFF_MASK;
      if (state_q == REQ && mem_req_ready)
        cnt_q <= '0;
      if (state_q == RECV && mem_resp_valid) begin
        line_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= mem_resp_data;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    data_csb      = 1'b1;
    data_web      = 1'b1;
    data_wmask    = '0;
    data_addr     = '0;
    data_din      = '0;
    fill_busy     = 1'b1;
    fill_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        fill_busy  = 1'b0;
        if (miss_valid)
          state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready)
          state_d = RECV;
      end
      RECV: begin
        if (mem_resp_valid && cnt_q == LAST)
          state_d = WRITE;
      end
      WRITE: begin
        data_csb   = 1'b0;
        data_web   = 1'b0;
        data_wmask = '1;
        data_addr  = index;
        data_din   = line_q;
        state_d    = COMMIT;
      end
      COMMIT: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ICACHE_FILL_BYPASS_EN
  // line_q is stable from WRITE until the next fill is accepted
  assign fill_line = (state_q == WRITE || state_q == COMMIT) ?
                     line_q : '0;
`else
  assign fill_line = '0;
`endif

endmodule

// File: tb/tb_icache_line_fill.sv
// Scoreboard bench for icache_line_fill: random fills checked against
// a line/index/timing model derived from the beat sequence.
module tb_icache_line_fill;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [63:0]  mem_resp_data;
  logic         data_csb;
  logic         data_web;
  logic [31:0]  data_wmask;
  logic [3:0]   data_addr;
  logic [255:0] data_din;
  logic         fill_busy;
  logic         fill_done;
  logic [255:0] fill_line;

  icache_line_fill dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .miss_valid     (miss_valid),
    .miss_addr      (miss_addr),
    .miss_ready     (miss_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .data_csb       (data_csb),
    .data_web       (data_web),
    .data_wmask     (data_wmask),
    .data_addr      (data_addr),
    .data_din       (data_din),
    .fill_busy      (fill_busy),
    .fill_done      (fill_done),
    .fill_line      (fill_line)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [255:0] line;
    int           wcyc;
  } exp_t;

  exp_t        wq[$];
  logic [31:0] rq[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          done_cyc = -1;
  logic [255:0] last_line = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic chk_rst();
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_csb", data_csb, 1);
    chk("rst_web", data_web, 1);
    chk("rst_wmask", data_wmask, 0);
    chk("rst_daddr", data_addr, 0);
    chk("rst_din", data_din, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_fill_line", fill_line, 0);
  endtask

  // Monitor: request address, array write and done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (mem_req_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_req", mem_req_valid, 0);
        end else begin
          chk("req_addr", mem_req_addr, rq[0]);
          if (mem_req_ready) void'(rq.pop_front());
        end
      end
      if (!data_csb) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", data_csb, 1);
        end else begin
          e = wq.pop_front();
          chk("w_addr", data_addr, e.idx);
          chk("w_din", data_din, e.line);
          chk("w_wmask", data_wmask, 32'hFFFF_FFFF);
          chk("w_web", data_web, 0);
          chk("w_cycle", cyc, e.wcyc);
          chk("w_busy", fill_busy, 1);
          last_line = e.line;
`ifdef ICACHE_FILL_BYPASS_EN
          chk("bypass_write", fill_line, e.line);
`endif
        end
        done_cyc = cyc + 1;
      end else begin
        chk("idle_port", {data_web, |data_wmask, |data_addr, |data_din},
            4'b1000);
      end
      if (cyc == done_cyc) begin
        chk("fill_done", fill_done, 1);
        chk("done_busy", fill_busy, 1);
        chk("done_miss_ready", miss_ready, 0);
`ifdef ICACHE_FILL_BYPASS_EN
        chk("bypass_commit", fill_line, last_line);
`endif
      end else if (fill_done) begin
        chk("spurious_done", fill_done, 0);
      end
`ifndef ICACHE_FILL_BYPASS_EN
      chk("fill_line_zero", fill_line, 0);
`endif
    end
  end

  task automatic accept(input logic [31:0] a, output int acc);
    bit ok;
    bit r;
    ok = 0;
    acc = -1;
    miss_valid = 1'b1;
    miss_addr  = a;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      r = miss_ready;
      @(posedge clk);
      #1;
      if (r) ok = 1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else acc = cyc;
  endtask

  task automatic do_fill(input logic [31:0] a, input int rd, input int g,
                         input bit pat, input bit spur, input bit hold,
                         input logic [31:0] na);
    logic [63:0] bt[4];
    int          gp[4];
    exp_t        e;
    int          acc;
    int          tot;
    e.line = '0;
    tot = 0;
    for (int b = 0; b < 4; b++) begin
      bt[b] = pat ? 64'h1111_1111_1111_1111 * 64'(b + 1)
                  : {$urandom, $urandom};
      gp[b] = (b == 0) ? 0 : (g < 0 ? int'($urandom_range(0, 2)) : g);
      tot += gp[b];
      e.line[64*b +: 64] = bt[b];
    end
    accept(a, acc);
    if (acc < 0) return;
    e.idx  = 4'(a >> 5);
    e.wcyc = acc + 5 + rd + tot;
    wq.push_back(e);
    rq.push_back(a & ~32'h1F);
    miss_valid = hold;
    if (hold) miss_addr = na;
    mem_resp_valid = spur;
    mem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      chk("req_valid_hold", mem_req_valid, 1);
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
    end
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      repeat (gp[b]) begin
        @(posedge clk);
        #1;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = bt[b];
      if (hold) begin
        @(negedge clk);
        chk("miss_ready_busy", miss_ready, 0);
      end
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
    end
  endtask

  task automatic do_reset_mid(input logic [31:0] a);
    int acc;
    accept(a, acc);
    if (acc < 0) return;
    rq.push_back(a & ~32'h1F);
    miss_valid    = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    mem_resp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_rst();
    rq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a1;
    logic [31:0] a2;
    rst_n          = 1'b0;
    miss_valid     = 1'b0;
    miss_addr      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_rst();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_fill(32'h0000_01A4, 0, 0, 1, 0, 0, 0);
    do_fill($urandom, 5, 0, 0, 0, 0, 0);
    do_fill($urandom, 1, 2, 0, 1, 0, 0);
    a1 = $urandom;
    a2 = $urandom;
    do_fill(a1, 0, 1, 0, 0, 1, a2);
    do_fill(a2, 0, 0, 0, 0, 0, 0);
    do_reset_mid($urandom);
    do_fill($urandom, 0, 0, 1, 0, 0, 0);
    repeat (30) begin
      do_fill($urandom, int'($urandom_range(0, 3)), -1, 0,
              1'($urandom_range(0, 1)), 0, 0);
    end
    miss_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("writes_pending", wq.size(), 0);
    chk("reqs_pending", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
